// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: PC register, PCSrc next-PC select, IF/ID latch,
// and interrupt synchronisation / tagging of the fetched slot.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [2:0]  redirect_sel,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jump_pc_plus4,
    input  logic [31:0] jr_target,
    input  logic        irq_raw,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        if_id_irq
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned KBIT     = XLEN - 1;
    localparam logic [2:0]  SEL_SEQ  = 3'd0;
    localparam logic [2:0]  SEL_BR   = 3'd1;
    localparam logic [2:0]  SEL_J    = 3'd2;
    localparam logic [2:0]  SEL_JR   = 3'd3;
    localparam logic [2:0]  SEL_IRQ  = 3'd4;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pp4_q, pp4_d;
    logic            valid_q, valid_d;
    logic            tag_q, tag_d;
    logic            irq_sync1_q, irq_sync2_q, irq_prev_q;
    logic            irq_pending_q, irq_pending_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            irq_edge;
    logic            irq_take;
    logic            if_load;
    logic            unused_ok;

    // Only the region bits of the jump's PC+4 are consumed.
    assign unused_ok = ^jump_pc_plus4[27:0];

    assign pc_plus4  = pc_q + XLEN'(4);
    assign irq_edge  = irq_sync2_q & ~irq_prev_q;
    assign irq_take  = irq_pending_q & ~pc_q[KBIT];
    assign if_load   = ~flush & ~stall;

    // Redirect target decode; user-mode non-vector redirects cannot enter kernel space.
    always_comb begin
        redirect_pc = XADR_PC;
        unique case (redirect_sel)
            SEL_SEQ: redirect_pc = pc_plus4;
            SEL_BR:  redirect_pc = branch_taken ? branch_target : pc_plus4;
            SEL_J:   redirect_pc = {jump_pc_plus4[31:28], jump_index, 2'b00};
            SEL_JR:  redirect_pc = jr_target;
            SEL_IRQ: redirect_pc = ILLOP_PC;
            default: redirect_pc = XADR_PC;
        endcase
        if (!pc_q[KBIT] && (redirect_sel < SEL_IRQ)) begin
            redirect_pc[KBIT] = 1'b0;
        end
    end

    // Next-PC priority: redirect over stall over sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // IF/ID latch update (flush beats stall) and pending-interrupt bookkeeping.
    always_comb begin
        instr_d       = instr_q;
        pp4_d         = pp4_q;
        valid_d       = valid_q;
        tag_d         = tag_q;
        irq_pending_d = irq_pending_q;
        if (flush) begin
            instr_d = '0;
            pp4_d   = '0;
            valid_d = 1'b0;
            tag_d   = 1'b0;
        end else if (!stall) begin
            instr_d = imem_rdata;
            pp4_d   = pc_plus4;
            valid_d = 1'b1;
            tag_d   = irq_take;
        end
        if (if_load && irq_take) begin
            irq_pending_d = 1'b0;
        end else if (irq_edge) begin
            irq_pending_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            pp4_q         <= '0;
            valid_q       <= 1'b0;
            tag_q         <= 1'b0;
            irq_sync1_q   <= 1'b0;
            irq_sync2_q   <= 1'b0;
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            pp4_q         <= pp4_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            irq_sync1_q   <= irq_raw;
            irq_sync2_q   <= irq_sync1_q;
            irq_prev_q    <= irq_sync2_q;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pp4_q;
    assign if_id_valid    = valid_q;
    assign if_id_irq      = tag_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Bench for if_stage_fetch: directed scenarios plus random traffic against a reference model.
module tb_if_stage_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [2:0]  redirect_sel;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jump_pc_plus4;
    logic [31:0] jr_target;
    logic        irq_raw;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        if_id_irq;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_irq, m_pend;
    bit          raw_hist[$];

    if_stage_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump_index     (jump_index),
        .jump_pc_plus4  (jump_pc_plus4),
        .jr_target      (jr_target),
        .irq_raw        (irq_raw),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .if_id_irq      (if_id_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address-dependent instruction memory contents
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        raw_hist.delete();
        repeat (3) raw_hist.push_back(1'b0);
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        take;
        logic        rise;
        if (reset) begin
            m_pc    = RESET_PC;
            m_instr = '0;
            m_pp4   = '0;
            m_valid = 1'b0;
            m_irq   = 1'b0;
            m_pend  = 1'b0;
            clear_hist();
            return;
        end
        seq  = m_pc + 32'd4;
        take = m_pend && !m_pc[31];
        // irq_raw sampled two clocks ago is high, three clocks ago low
        rise = raw_hist[1] && !raw_hist[2];
        if (flush) begin
            m_instr = '0;
            m_pp4   = '0;
            m_valid = 1'b0;
            m_irq   = 1'b0;
        end else if (!stall) begin
            m_instr = mem_word(m_pc);
            m_pp4   = seq;
            m_valid = 1'b1;
            m_irq   = take;
        end
        if (!flush && !stall && take) m_pend = 1'b0;
        else if (rise)                m_pend = 1'b1;
        if (redirect_valid) begin
            case (redirect_sel)
                3'd0:    tgt = seq;
                3'd1:    tgt = branch_taken ? branch_target : seq;
                3'd2:    tgt = {jump_pc_plus4[31:28], jump_index, 2'b00};
                3'd3:    tgt = jr_target;
                3'd4:    tgt = ILLOP_PC;
                default: tgt = XADR_PC;
            endcase
            if (redirect_sel < 3'd4 && !m_pc[31]) tgt[31] = 1'b0;
            m_pc = tgt;
        end else if (!stall) begin
            m_pc = seq;
        end
        raw_hist.push_front(irq_raw);
        void'(raw_hist.pop_back());
    endtask

    // One clock: update model, clock DUT, compare all outputs shortly after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk32("imem_addr", imem_addr, m_pc);
        chk32("if_id_instr", if_id_instr, m_instr);
        chk32("if_id_pc_plus4", if_id_pc_plus4, m_pp4);
        chk1("if_id_valid", if_id_valid, m_valid);
        chk1("if_id_irq", if_id_irq, m_irq);
    endtask

    task automatic redirect(input logic [2:0] sel);
        redirect_valid = 1'b1;
        redirect_sel   = sel;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic irq_pulse();
        irq_raw = 1'b1;
        tick();
        irq_raw = 1'b0;
    endtask

    initial begin
        int tags;
        int first_k;
        m_pc = '0; m_instr = '0; m_pp4 = '0;
        m_valid = 1'b0; m_irq = 1'b0; m_pend = 1'b0;
        clear_hist();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        redirect_valid = 1'b0; redirect_sel = 3'd0; branch_taken = 1'b0;
        branch_target = '0; jump_index = '0; jump_pc_plus4 = '0; jr_target = '0;
        irq_raw = 1'b0;

        // Reset and sequential fetch
        tick(); tick();
        chk32("reset_pc", imem_addr, 32'h8000_0000);
        chk1("reset_valid", if_id_valid, 1'b0);
        reset = 1'b0;
        tick();
        chk32("seq1_pc", imem_addr, 32'h8000_0004);
        chk32("seq1_pp4", if_id_pc_plus4, 32'h8000_0004);
        tick();
        chk32("seq2_pc", imem_addr, 32'h8000_0008);
        chk32("seq2_pp4", if_id_pc_plus4, 32'h8000_0008);
        tick();
        chk32("seq3_pc", imem_addr, 32'h8000_000C);

        // Stall freezes PC and IF/ID
        jr_target = 32'h0040_0010;
        redirect(3'd3);
        chk32("jr_kernel_to_user", imem_addr, 32'h0040_0010);
        stall = 1'b1;
        tick(); tick();
        chk32("stall_pc", imem_addr, 32'h0040_0010);
        chk32("stall_pp4", if_id_pc_plus4, 32'h8000_0010);
        chk32("stall_instr", if_id_instr, mem_word(32'h8000_000C));
        stall = 1'b0;
        tick();
        chk32("release_pc", imem_addr, 32'h0040_0014);
        chk32("release_pp4", if_id_pc_plus4, 32'h0040_0014);

        // Branch taken with flush, then not taken
        branch_taken = 1'b1; branch_target = 32'h0040_0100; flush = 1'b1;
        redirect(3'd1);
        flush = 1'b0;
        chk32("br_taken_pc", imem_addr, 32'h0040_0100);
        chk1("br_flush_valid", if_id_valid, 1'b0);
        chk32("br_flush_instr", if_id_instr, 32'h0);
        branch_taken = 1'b0;
        redirect(3'd1);
        chk32("br_not_taken_pc", imem_addr, 32'h0040_0104);

        // jr kernel-bit guard and jump
        jr_target = 32'h0040_0020;
        redirect(3'd3);
        jr_target = 32'h8000_1000;
        redirect(3'd3);
        chk32("jr_user_guard", imem_addr, 32'h0000_1000);
        redirect(3'd4);
        chk32("irq_vector", imem_addr, 32'h8000_0004);
        redirect(3'd3);
        chk32("jr_kernel", imem_addr, 32'h8000_1000);
        jump_index = 26'h010_0000; jump_pc_plus4 = 32'h0040_0024;
        redirect(3'd2);
        chk32("jump_pc", imem_addr, 32'h0040_0000);

        // Interrupt in user mode tags exactly one slot
        tags = 0; first_k = 0;
        irq_pulse();
        if (if_id_irq) begin tags++; first_k = 1; end
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (if_id_irq) begin
                tags++;
                if (first_k == 0) first_k = k;
            end
        end
        chk32("irq_user_tag_count", 32'(tags), 32'd1);
        chk1("irq_user_latency", (first_k >= 3 && first_k <= 4), 1'b1);

        // Interrupt held off in kernel mode until PC[31] clears
        redirect(3'd4);
        jr_target = 32'h8000_0100;
        redirect(3'd3);
        chk32("kernel_pc", imem_addr, 32'h8000_0100);
        tags = 0;
        irq_pulse();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (if_id_irq) tags++;
        end
        chk32("irq_kernel_no_tag", 32'(tags), 32'd0);
        jr_target = 32'h0040_0000;
        redirect(3'd3);
        chk1("irq_kernel_slot_untagged", if_id_irq, 1'b0);
        tick();
        chk1("irq_deferred_tag", if_id_irq, 1'b1);

        // Flushed tagged slot is retagged on the next load
        irq_pulse();
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk1("irq_flushed_tag", if_id_irq, 1'b0);
        chk1("irq_flushed_valid", if_id_valid, 1'b0);
        tick();
        chk1("irq_retag", if_id_irq, 1'b1);
        tick();
        chk1("irq_cleared", if_id_irq, 1'b0);

        // 32-bit wrap and reserved select codes
        redirect(3'd4);
        jr_target = 32'hFFFF_FFFC;
        redirect(3'd3);
        chk32("wrap_start", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk32("wrap_pc", imem_addr, 32'h0000_0000);
        redirect(3'd7);
        chk32("sel7_pc", imem_addr, 32'h8000_0008);
        redirect(3'd6);
        chk32("sel6_pc", imem_addr, 32'h8000_0008);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 49) == 0);
            stall          = ($urandom_range(0, 4) == 0);
            flush          = ($urandom_range(0, 6) == 0);
            redirect_valid = ($urandom_range(0, 3) == 0);
            redirect_sel   = 3'($urandom_range(0, 7));
            branch_taken   = 1'($urandom_range(0, 1));
            branch_target  = $urandom & 32'hFFFF_FFFC;
            jump_index     = 26'($urandom);
            jump_pc_plus4  = $urandom & 32'hFFFF_FFFC;
            jr_target      = $urandom & 32'hFFFF_FFFC;
            if (!m_pc[31]) begin
                branch_target[31] = 1'b0;
                jump_pc_plus4[31] = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) irq_raw = ~irq_raw;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
